uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
- Oversampling UART receiver. It sits directly upstream of the AES UART command FSM and feeds it the `'K'`/`'E'`/`'D'` command bytes and the 16-byte payloads.
- Replaces naive mid-bit sampling with three measures:
  - a two-flop synchronizer;
  - 16x oversampling with 3-sample majority vote;
  - false-start rejection and framing-error reporting.
- Output contract: one-cycle `rx_valid` pulse with `rx_data` stable until the next accepted byte.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD, 115_200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit. Fixed to 16; majority taps at ticks 7, 8, 9.
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE), clocks per tick, integer division. 27 at defaults. Must be >= 2; elaboration error otherwise.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_serial  in  1  asynchronous serial line; idle high.
- rx_data  out  8  last correctly framed byte, LSB received first.
- rx_valid  out  1  one-cycle pulse; new byte on rx_data.
- rx_ferr  out  1  one-cycle pulse; stop bit sampled low.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - rx_data = 8'h00, rx_valid = 0, rx_ferr = 0, rx_busy = 0.
  - Both synchronizer flops = 1.
  - Tick counter = 0, state = IDLE.
- Synchronizer: rx_s = second flop of rx_serial. All decisions use rx_s only; 2-cycle input latency.
- Tick generator:
  - Free-running 0..TICK_DIV-1. Emits tick for one cycle at TICK_DIV-1, then wraps to 0.
  - Counter is never re-phased. Start-edge uncertainty is therefore <= 1 tick, i.e. 1/16 bit.
- Sample counter scnt: 4 bits, advances on tick, wraps 15 -> 0. Bit counter bcnt: 3 bits.
- State machine, all transitions on tick cycles only:
  - IDLE: if rx_s == 0, go to START with scnt = 0.
  - START:
    - Capture rx_s at scnt 7, 8, 9.
    - At scnt 9, evaluate majority. If 1, it is a false start: go to IDLE with no pulse.
    - At scnt 15, go to DATA with bcnt = 0.
  - DATA:
    - Capture at scnt 7, 8, 9.
    - At scnt 9, shift the majority into shreg MSB (right shift, LSB-first).
    - At scnt 15: if bcnt == 7, go to STOP; else bcnt++.
  - STOP: capture at scnt 7, 8, 9; majority evaluated at scnt 9.
    - Majority 1: rx_data <= shreg and rx_valid pulses on the next cycle. Go to IDLE at scnt 9, half-bit early so back-to-back frames are caught.
    - Majority 0: rx_ferr pulses on the next cycle; rx_data is unchanged. Go to WAIT_HI.
  - WAIT_HI (break/line-low recovery): stay until a tick with rx_s == 1, then go to IDLE.
- rx_valid and rx_ferr are mutually exclusive and never high for more than one cycle.
- Latency: from the rx_serial start edge to rx_valid ≈ 9.5 bit times + 3 clk ± 1 tick.
- No receive FIFO; consumers sample rx_data on rx_valid. rx_data changes only on a valid frame.
- rst asserted mid-frame: next cycle all outputs are at reset values and state = IDLE. Partial byte discarded; no pulse.
- Majority function: (a&b)|(a&c)|(b&c).

Decomposition:
- Shared package aes_uart_pkg (shared by all UART stages):
  - state encodings: IDLE=0, START=1, DATA=2, STOP=3, WAIT_HI=4;
  - OVERSAMPLE = 16;
  - sample taps MID_LO = 7, MID = 8, MID_HI = 9;
  - majority3 function.
- Sub-module uart_baud_tick (params CLK_FREQ, BAUD, OVERSAMPLE; ports clk, rst, tick):
  - reused later by the oversampled transmitter.
- Remaining FSM, synchronizer and shift register are inline; roughly 150–200 lines total.

Test Plan:
- Defaults (TICK_DIV=27, bit = 432 clk). Send 8'h4B, 8N1 → exactly one rx_valid pulse, rx_data=8'h4B, rx_ferr never high, rx_busy low after mid-stop.
- Low glitch of 100 clk on idle line → no rx_valid, no rx_ferr; FSM back in IDLE before 10 ticks. A following 8'h45 is received correctly.
- 8'h45 with stop bit driven low, line held low 2 bit times then high → one rx_ferr pulse, rx_data holds previous 8'h4B. Next frame 8'h44 is only accepted after the line returns high, and yields rx_data=8'h44.
- Back-to-back burst of 17 bytes, zero idle gap: 'K' (8'h4B) then 8'h00..8'h0F → 17 rx_valid pulses in order, values matching, no ferr.
- Single-clock inverted spike at tick 8 of data bit 3 in byte 8'hA5 → majority masks it, rx_data=8'hA5.
- rst asserted for 1 clk during data bit 4 of 8'hFF → outputs 0 the next cycle, no pulse. A subsequent full 8'h3C gives rx_data=8'h3C.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// rtl/aes_uart_pkg.sv - shared UART receive-path types, sample taps and vote helper
package aes_uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } uart_rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Three taps straddling the bit centre
    localparam logic [3:0] MID_LO = 4'd7;
    localparam logic [3:0] MID    = 4'd8;
    localparam logic [3:0] MID_HI = 4'd9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick divider
module uart_baud_tick #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW       = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $error("uart_baud_tick: TICK_DIV must be >= 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // Divider runs continuously; it is never re-phased by line activity
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x oversampling UART receiver with majority vote and framing check
module uart_rx_os
    import aes_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_busy
);

    generate
        if (OVERSAMPLE != 16) begin : g_bad_os
            $error("uart_rx_os: OVERSAMPLE must be 16");
        end
    endgenerate

    localparam logic [3:0] SCNT_LAST = 4'(OVERSAMPLE - 1);

    logic           tick;
    logic [1:0]     sync;
    logic           rx_s;

    uart_rx_state_t state, state_n;
    logic [3:0]     scnt, scnt_n, scnt_adv;
    logic [2:0]     bcnt, bcnt_n;
    logic [7:0]     shreg, shreg_n;
    logic [7:0]     data_n;
    logic           s_lo, s_lo_n;
    logic           s_mid, s_mid_n;
    logic           valid_n, ferr_n;
    logic           maj;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign rx_s     = sync[1];
    assign scnt_adv = scnt + 4'd1;
    // Third vote comes straight from the line on the MID_HI tick itself
    assign maj      = majority3(s_lo, s_mid, rx_s);
    assign rx_busy  = (state != IDLE);

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx_serial};
        end
    end

    // FSM state, counters, shift register and registered output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            scnt     <= 4'd0;
            bcnt     <= 3'd0;
            shreg    <= 8'h00;
            s_lo     <= 1'b1;
            s_mid    <= 1'b1;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            state    <= state_n;
            scnt     <= scnt_n;
            bcnt     <= bcnt_n;
            shreg    <= shreg_n;
            s_lo     <= s_lo_n;
            s_mid    <= s_mid_n;
            rx_data  <= data_n;
            rx_valid <= valid_n;
            rx_ferr  <= ferr_n;
        end
    end

    // Next-state: every decision is taken on a tick cycle only
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        s_lo_n  = s_lo;
        s_mid_n = s_mid;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;

        if (tick && (state == START || state == DATA || state == STOP)) begin
            scnt_n = scnt_adv;
            if (scnt_adv == MID_LO) s_lo_n  = rx_s;
            if (scnt_adv == MID)    s_mid_n = rx_s;
        end

        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        scnt_n  = 4'd0;
                    end
                end
                START: begin
                    if (scnt_adv == MID_HI && maj) begin
                        state_n = IDLE;
                    end else if (scnt_adv == SCNT_LAST) begin
                        state_n = DATA;
                        bcnt_n  = 3'd0;
                    end
                end
                DATA: begin
                    if (scnt_adv == MID_HI) begin
                        shreg_n = {maj, shreg[7:1]};
                    end
                    if (scnt_adv == SCNT_LAST) begin
                        if (bcnt == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            bcnt_n = bcnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed
                    if (scnt_adv == MID_HI) begin
                        if (maj) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    if (rx_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
